// File: rtl/data_mem_unit.sv
// data_mem_unit: multi-cycle data memory stage for the 64-bit RISC-V pipeline.
// Performs sized little-endian loads and stores against an internal byte
// array. While an access is in flight it holds `stall` high to freeze the
// upstream pipeline. Load data appears on `readdata` in the cycle `stall`
// drops.
module data_mem_unit #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] readdata,
  output logic        stall,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [7:0]    mem [DEPTH_BYTES];

  logic          req;
  logic          misaligned;
  logic          illegal;
  logic          valid;
  logic [7:0]    byte_en;
  logic [AW-1:0] idx;
  logic [63:0]   raw;
  logic [63:0]   load_ext;

  // Upper address bits are ignored: the array aliases across the address space.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[63:AW];
  assign idx = addr[AW-1:0];

  // Decode the request: size, alignment, funct3 legality and byte enables.
  always_comb begin
    req        = memread | memwrite;
    misaligned = 1'b0;
    byte_en    = 8'h01;
    case (funct3[1:0])
      2'd0: begin misaligned = 1'b0;        byte_en = 8'h01; end
      2'd1: begin misaligned = addr[0];     byte_en = 8'h03; end
      2'd2: begin misaligned = |addr[1:0];  byte_en = 8'h0F; end
      default: begin misaligned = |addr[2:0]; byte_en = 8'hFF; end
    endcase
    // A simultaneous read+write is a store, so store legality applies.
    illegal = memwrite ? funct3[2] : (funct3 == 3'b111);
    valid   = req & ~misaligned & ~illegal;
  end

  // Gather eight little-endian bytes from the index; aligned accesses never wrap.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      raw[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  // Extend the gathered bytes according to load size and signedness.
  always_comb begin
    case (funct3)
      3'b000:  load_ext = {{56{raw[7]}},  raw[7:0]};
      3'b001:  load_ext = {{48{raw[15]}}, raw[15:0]};
      3'b010:  load_ext = {{32{raw[31]}}, raw[31:0]};
      3'b011:  load_ext = raw;
      3'b100:  load_ext = {56'd0, raw[7:0]};
      3'b101:  load_ext = {48'd0, raw[15:0]};
      3'b110:  load_ext = {32'd0, raw[31:0]};
      default: load_ext = '0;
    endcase
  end

  // Stall is raised in the request cycle itself so EX/MEM never advances past it.
  assign stall = (state == WAIT) | ((state == IDLE) & valid);
  assign fault = (state == IDLE) & req & ~valid;

  // Access FSM: count down the wait cycles, then commit the store or load.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      readdata <= '0;
      // NOTE: the array is cleared on reset because a reset must leave all
      // bytes zero; this forces flops rather than a RAM macro.
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            count <= CW'(LATENCY - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else begin
            state <= DONE;
            if (memwrite) begin
              for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                  mem[idx + AW'(i)] <= wdata[8*i +: 8];
                end
              end
              if (memread) begin
                readdata <= '0;
              end
            end else begin
              readdata <= load_ext;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Testbench for data_mem_unit. Two instances: index 0 uses LATENCY=2 and
// index 1 uses LATENCY=1. Both use DEPTH_BYTES=256. A byte-array reference
// model predicts load results, fault decisions and stall length.
module tb_data_mem_unit;

  logic        clk;
  logic        rst_v      [2];
  logic        memread_v  [2];
  logic        memwrite_v [2];
  logic [2:0]  funct3_v   [2];
  logic [63:0] addr_v     [2];
  logic [63:0] wdata_v    [2];
  logic [63:0] readdata_v [2];
  logic        stall_v    [2];
  logic        fault_v    [2];

  logic [7:0]  mem_m [2][256];
  logic [63:0] rd_m  [2];

  int errors = 0;
  int checks = 0;

  data_mem_unit #(.DEPTH_BYTES(256), .LATENCY(2)) dut0 (
    .clk(clk), .reset(rst_v[0]), .memread(memread_v[0]), .memwrite(memwrite_v[0]),
    .funct3(funct3_v[0]), .addr(addr_v[0]), .wdata(wdata_v[0]),
    .readdata(readdata_v[0]), .stall(stall_v[0]), .fault(fault_v[0])
  );

  data_mem_unit #(.DEPTH_BYTES(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst_v[1]), .memread(memread_v[1]), .memwrite(memwrite_v[1]),
    .funct3(funct3_v[1]), .addr(addr_v[1]), .wdata(wdata_v[1]),
    .readdata(readdata_v[1]), .stall(stall_v[1]), .fault(fault_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model(input int inst);
    for (int i = 0; i < 256; i++) mem_m[inst][i] = 8'h00;
    rd_m[inst] = 64'd0;
  endtask

  // Expected load value: assemble n bytes little-endian, then extend.
  function automatic logic [63:0] model_load(input int inst, input logic [2:0] f3,
                                             input logic [63:0] a);
    logic [63:0] v;
    int n;
    int base;
    v = 64'd0;
    n = 1 << f3[1:0];
    base = int'(a[7:0]);
    for (int i = 0; i < n; i++) v = v | (64'(mem_m[inst][(base + i) % 256]) << (8 * i));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  // One access on instance inst; checks fault/stall timing and readdata.
  task automatic access(input int inst, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input string name);
    int  lat;
    int  n;
    int  cnt;
    bit  ok;
    int  base;
    lat  = (inst == 0) ? 2 : 1;
    n    = 1 << f3[1:0];
    ok   = (rd || wr) && ((a % 64'(n)) == 64'd0) && (wr ? (f3[2] == 1'b0) : (f3 != 3'b111));
    @(posedge clk); #1;
    memread_v[inst] = rd; memwrite_v[inst] = wr; funct3_v[inst] = f3;
    addr_v[inst] = a; wdata_v[inst] = wd;
    #1;
    if (!ok) begin
      checks++;
      if (fault_v[inst] !== 1'b1 || stall_v[inst] !== 1'b0) begin
        errors++;
        $display("FAIL %s fault/stall: got fault=%b stall=%b want fault=1 stall=0",
                 name, fault_v[inst], stall_v[inst]);
      end
      @(posedge clk); #2;
      checks++;
      if (readdata_v[inst] !== rd_m[inst]) begin
        errors++;
        $display("FAIL %s readdata after fault: got %h want %h", name, readdata_v[inst], rd_m[inst]);
      end
      memread_v[inst] = 1'b0; memwrite_v[inst] = 1'b0;
      return;
    end
    checks++;
    if (stall_v[inst] !== 1'b1 || fault_v[inst] !== 1'b0) begin
      errors++;
      $display("FAIL %s request cycle: got stall=%b fault=%b want stall=1 fault=0",
               name, stall_v[inst], fault_v[inst]);
    end
    cnt = 1;
    forever begin
      @(posedge clk); #2;
      if (stall_v[inst] !== 1'b1) break;
      cnt++;
      if (cnt > 20) break;
    end
    // Commit into the model.
    if (wr) begin
      base = int'(a[7:0]);
      for (int i = 0; i < n; i++) mem_m[inst][(base + i) % 256] = wd[8*i +: 8];
      if (rd) rd_m[inst] = 64'd0;
    end else begin
      rd_m[inst] = model_load(inst, f3, a);
    end
    checks++;
    if (cnt != lat + 1) begin
      errors++;
      $display("FAIL %s stall length: got %0d cycles want %0d", name, cnt, lat + 1);
    end
    checks++;
    if (readdata_v[inst] !== rd_m[inst] || fault_v[inst] !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got readdata=%h fault=%b want readdata=%h fault=0",
               name, readdata_v[inst], fault_v[inst], rd_m[inst]);
    end
    memread_v[inst] = 1'b0; memwrite_v[inst] = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (readdata_v[k] !== 64'd0 || stall_v[k] !== 1'b0 || fault_v[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset%0d: got readdata=%h stall=%b fault=%b want 0/0/0",
                 k, readdata_v[k], stall_v[k], fault_v[k]);
      end
    end
  endtask

  task automatic test_dword;
    access(0, 1'b0, 1'b1, 3'b011, 64'h10, 64'h1122334455667788, "sd_0x10");
    access(0, 1'b1, 1'b0, 3'b011, 64'h10, 64'd0, "ld_0x10");
    checks++;
    if (readdata_v[0] !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL ld_0x10 value: got %h want 1122334455667788", readdata_v[0]);
    end
  endtask

  task automatic test_sign_ext;
    access(0, 1'b0, 1'b1, 3'b000, 64'h21, 64'h80, "sb_0x21");
    access(0, 1'b1, 1'b0, 3'b000, 64'h21, 64'd0, "lb_0x21");
    checks++;
    if (readdata_v[0] !== 64'hFFFFFFFFFFFFFF80) begin
      errors++;
      $display("FAIL lb_0x21 value: got %h want ffffffffffffff80", readdata_v[0]);
    end
    access(0, 1'b1, 1'b0, 3'b100, 64'h21, 64'd0, "lbu_0x21");
    checks++;
    if (readdata_v[0] !== 64'h0000000000000080) begin
      errors++;
      $display("FAIL lbu_0x21 value: got %h want 0000000000000080", readdata_v[0]);
    end
    access(0, 1'b1, 1'b0, 3'b001, 64'h20, 64'd0, "lh_0x20");
    checks++;
    if (readdata_v[0] !== 64'hFFFFFFFFFFFF8000) begin
      errors++;
      $display("FAIL lh_0x20 value: got %h want ffffffffffff8000", readdata_v[0]);
    end
  endtask

  task automatic test_fault;
    access(0, 1'b1, 1'b0, 3'b010, 64'h22, 64'd0, "lw_misaligned");
    access(0, 1'b1, 1'b0, 3'b011, 64'h20, 64'd0, "ld_0x20_after_fault");
    access(0, 1'b1, 1'b0, 3'b111, 64'h20, 64'd0, "load_f3_111");
    access(0, 1'b0, 1'b1, 3'b100, 64'h20, 64'hFF, "store_f3_100");
    access(0, 1'b0, 1'b1, 3'b011, 64'h24, 64'hFF, "sd_misaligned");
    access(0, 1'b1, 1'b0, 3'b011, 64'h20, 64'd0, "ld_0x20_after_bad_store");
  endtask

  task automatic test_reset_inflight;
    @(posedge clk); #1;
    memwrite_v[0] = 1'b1; funct3_v[0] = 3'b011; addr_v[0] = 64'h30; wdata_v[0] = '1;
    @(posedge clk);
    @(posedge clk); #2;
    checks++;
    if (stall_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_inflight pre: got stall=%b want 1", stall_v[0]);
    end
    rst_v[0] = 1'b1; memwrite_v[0] = 1'b0;
    clear_model(0);
    #1;
    checks++;
    if (stall_v[0] !== 1'b0 || readdata_v[0] !== 64'd0) begin
      errors++;
      $display("FAIL rst_inflight drop: got stall=%b readdata=%h want 0/0", stall_v[0], readdata_v[0]);
    end
    @(negedge clk); @(negedge clk);
    rst_v[0] = 1'b0;
    access(0, 1'b1, 1'b0, 3'b011, 64'h30, 64'd0, "ld_0x30_after_reset");
    access(0, 1'b1, 1'b0, 3'b011, 64'h10, 64'd0, "ld_0x10_after_reset");
  endtask

  task automatic test_collision;
    access(0, 1'b1, 1'b1, 3'b010, 64'h40, 64'hDEADBEEF, "rw_sw_0x40");
    access(0, 1'b1, 1'b0, 3'b110, 64'h40, 64'd0, "lwu_0x40");
    checks++;
    if (readdata_v[0] !== 64'h00000000DEADBEEF) begin
      errors++;
      $display("FAIL lwu_0x40 value: got %h want 00000000deadbeef", readdata_v[0]);
    end
  endtask

  task automatic test_alias;
    access(1, 1'b0, 1'b1, 3'b011, 64'h108, 64'hCAFEF00D12345678, "sd_0x108");
    access(1, 1'b1, 1'b0, 3'b011, 64'h08, 64'd0, "ld_0x08");
    checks++;
    if (readdata_v[1] !== 64'hCAFEF00D12345678) begin
      errors++;
      $display("FAIL alias ld_0x08 value: got %h want cafef00d12345678", readdata_v[1]);
    end
  endtask

  task automatic test_random(input int inst, input int count);
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] wd;
    int          kind;
    bit          rd;
    bit          wr;
    for (int t = 0; t < count; t++) begin
      f3   = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      rd   = (kind <= 4) || (kind == 9);
      wr   = (kind >= 5);
      a    = {$urandom, $urandom};
      a[7:0] = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
      wd   = {$urandom, $urandom};
      access(inst, rd, wr, f3, a, wd, $sformatf("rand%0d_%0d", inst, t));
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; memread_v[k] = 1'b0; memwrite_v[k] = 1'b0;
      funct3_v[k] = 3'd0; addr_v[k] = 64'd0; wdata_v[k] = 64'd0;
      clear_model(k);
    end
    #12;
    test_reset;
    @(negedge clk);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    test_dword;
    test_sign_ext;
    test_fault;
    test_reset_inflight;
    test_collision;
    test_alias;
    test_random(0, 80);
    test_random(1, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
